operand_issue: RTL

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/operand_issue.sv
// Operand issue stage: resolves source operands through write-port bypass or the
// register-file scoreboard, reserves the destination, and holds one instruction for execute.
module operand_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [15:0] in_ctrl,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_wb,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic        rf_rs1_valid,
    input  logic        rf_rs2_valid,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic [4:0]  rf_rd,
    output logic        rf_reserve,
    input  logic [4:0]  wreg0,
    input  logic [31:0] wdata0,
    input  logic        wen0,
    input  logic [4:0]  wreg1,
    input  logic [31:0] wdata1,
    input  logic        wen1,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [15:0] ex_ctrl,
    output logic [4:0]  ex_rd,
    output logic        ex_wb,
    output logic [31:0] stall_count
);

    // Returns {ready, value}; x0 first, then write port 0, then port 1, then the file.
    function automatic logic [32:0] resolve(
        input logic [4:0]  rs,
        input logic        rf_valid,
        input logic [31:0] rf_data,
        input logic        w0_en,
        input logic [4:0]  w0_reg,
        input logic [31:0] w0_data,
        input logic        w1_en,
        input logic [4:0]  w1_reg,
        input logic [31:0] w1_data
    );
        logic [32:0] r;
        r = {rf_valid, rf_data};
        if (rs == 5'd0)
            r = {1'b1, 32'd0};
        else if (w0_en && (w0_reg == rs))
            r = {1'b1, w0_data};
        else if (w1_en && (w1_reg == rs))
            r = {1'b1, w1_data};
        return r;
    endfunction

    logic [32:0] op1_res, op2_res;
    logic        ops_ready, fire;

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
    logic [31:0] ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
    logic [15:0] ex_ctrl_q, ex_ctrl_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_wb_q, ex_wb_d;
    logic [31:0] stall_q, stall_d;

    assign op1_res = resolve(in_rs1, rf_rs1_valid, rf_rs1_data, wen0, wreg0, wdata0, wen1, wreg1, wdata1);
    assign op2_res = resolve(in_rs2, rf_rs2_valid, rf_rs2_data, wen0, wreg0, wdata0, wen1, wreg1, wdata1);

    assign ops_ready  = op1_res[32] & op2_res[32];
    assign in_ready   = ~reset & ~flush & ops_ready & (~ex_valid_q | ex_ready);
    assign fire       = in_valid & in_ready;
    assign rf_rs1     = in_rs1;
    assign rf_rs2     = in_rs2;
    assign rf_rd      = in_rd;
    assign rf_reserve = fire & in_wb & (in_rd != 5'd0);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_imm_d   = ex_imm_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        ex_wb_d    = ex_wb_q;
        stall_d    = stall_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (fire) begin
            ex_valid_d = 1'b1;
            ex_pc_d    = in_pc;
            ex_imm_d   = in_imm;
            ex_op1_d   = op1_res[31:0];
            ex_op2_d   = op2_res[31:0];
            ex_ctrl_d  = in_ctrl;
            ex_rd_d    = in_rd;
            ex_wb_d    = in_wb;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end
        // Only operand stalls count; backpressure with ready operands does not.
        if (in_valid && !flush && !ops_ready)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_imm_q   <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            ex_wb_q    <= 1'b0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_imm_q   <= ex_imm_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            ex_wb_q    <= ex_wb_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_imm      = ex_imm_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_rd       = ex_rd_q;
    assign ex_wb       = ex_wb_q;
    assign stall_count = stall_q;

endmodule
